// File: rtl/key_expand_multi_if.sv
// Handshake/bus bundle between the key-expansion block and its user.
interface key_expand_multi_if;
  logic        start;
  logic [1:0]  key_mode;
  logic [31:0] cipher_key;
  logic [3:0]  round_key_num;
  logic [1:0]  r_index;
  logic [31:0] round_key;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output start, key_mode, cipher_key, round_key_num, r_index,
    input  round_key, done, busy, err
  );

  modport slave (
    input  start, key_mode, cipher_key, round_key_num, r_index,
    output round_key, done, busy, err
  );
endinterface

// File: rtl/key_expand_multi.sv
// AES-128/192/256 key schedule: Nk load cycles then one expanded word per clock (done 44/52/60 clocks after start).
// No backpressure: start is ignored while busy; round_key is combinational or one-cycle registered per READ_REG.
module key_expand_multi #(
  parameter int MAX_NK   = 8,
  parameter bit READ_REG = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  key_expand_multi_if.slave  bus
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX_TBL[idx*8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [5:0]  cnt_q;
  logic [2:0]  mod_q;
  logic [3:0]  rcon_idx_q;
  logic [3:0]  nk_q, nr_q;
  logic        err_q;
  logic [31:0] rd_q, rd_d;

  logic        mode_ok, start_ok, start_bad, idle_like;
  logic [3:0]  nk_new;
  logic        load_last, exp_last, mod_wrap;
  logic        load_we, exp_we, busy_o, done_o;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, new_word;

  // Modes wider than the storage was built for behave exactly like key_mode=3.
  always_comb begin
    mode_ok = 1'b0;
    nk_new  = 4'd4;
    case (bus.key_mode)
      2'd0: mode_ok = 1'b1;
      2'd1: begin nk_new = 4'd6; mode_ok = (MAX_NK >= 6); end
      2'd2: begin nk_new = 4'd8; mode_ok = (MAX_NK >= 8); end
      default: ;
    endcase
  end

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok  = bus.start && idle_like && mode_ok;
  assign start_bad = bus.start && idle_like && !mode_ok;
  assign load_last = (cnt_q == {2'b00, nk_q - 4'd1});
  assign exp_last  = (cnt_q == {nr_q, 2'b11});
  assign mod_wrap  = ({1'b0, mod_q} == (nk_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_LOAD;
      S_LOAD:         if (load_last) state_d = S_EXPAND;
      S_EXPAND:       if (exp_last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_we = 1'b0;
    exp_we  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_LOAD:   begin load_we = 1'b1; busy_o = 1'b1; end
      S_EXPAND: begin exp_we  = 1'b1; busy_o = 1'b1; end
      S_DONE:   done_o = 1'b1;
      default:  ;
    endcase
  end

  // Single S-box word per cycle: the rotated or plain w[i-1] feeds the same four byte lookups.
  assign w_prev   = mem_q[cnt_q - 6'd1];
  assign w_back   = mem_q[cnt_q - {2'b00, nk_q}];
  assign sub_in   = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};

  always_comb begin
    temp = w_prev;
    if (mod_q == 3'd0)
      temp = sub_out ^ {rcon(rcon_idx_q), 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      temp = sub_out;
  end

  assign new_word = w_back ^ temp;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      cnt_q      <= '0;
      mod_q      <= '0;
      rcon_idx_q <= 4'd1;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        nk_q       <= nk_new;
        nr_q       <= nk_new + 4'd6;
        err_q      <= 1'b0;
        cnt_q      <= '0;
        mod_q      <= '0;
        rcon_idx_q <= 4'd1;
      end else if (start_bad) begin
        err_q <= 1'b1;
      end
      if (load_we) begin
        mem_q[cnt_q] <= bus.cipher_key;
        cnt_q        <= cnt_q + 6'd1;
      end
      if (exp_we) begin
        mem_q[cnt_q] <= new_word;
        cnt_q        <= cnt_q + 6'd1;
        mod_q        <= mod_wrap ? 3'd0 : mod_q + 3'd1;
        if (mod_wrap) rcon_idx_q <= rcon_idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    if (bus.round_key_num <= nr_q && bus.round_key_num <= 4'd14)
      rd_d = mem_q[{bus.round_key_num, bus.r_index}];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign bus.round_key = READ_REG ? rd_q : rd_d;
  assign bus.done      = done_o;
  assign bus.busy      = busy_o;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_key_expand_multi.sv
// Randomized bench for key_expand_multi against a FIPS-197 key-schedule model with an arithmetic S-box.
module tb_key_expand_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_expand_multi_if bus();

  key_expand_multi #(.MAX_NK(8), .READ_REG(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb [256];
  logic [31:0] cur_key [8];
  logic [31:0] exp_w [60];
  int          exp_nr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input int mode);
    int nk, nr;
    logic [7:0]  rc [11];
    logic [31:0] t;
    nk = 4 + 2 * mode;
    nr = nk + 6;
    exp_nr = nr;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int q = 2; q <= 10; q++) rc[q] = gmul(rc[q-1], 8'h02);
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) exp_w[i] = cur_key[i];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = exp_w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rc[i / nk], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    exp_nr = 14;
  endtask

  function automatic logic [31:0] exp_rd(input int rkn, input int idx);
    if (rkn > exp_nr || rkn > 14) return 32'h0;
    return exp_w[4 * rkn + idx];
  endfunction

  task automatic rd(input int rkn, input int idx, output logic [31:0] v);
    bus.round_key_num = 4'(rkn);
    bus.r_index       = 2'(idx);
    @(negedge clk);
    v = bus.round_key;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 4; j++) begin
        rd(r, j, v);
        check($sformatf("%s rk%0d.%0d", tag, r, j), v, exp_rd(r, j));
      end
  endtask

  task automatic do_load(input int mode, input int inject_cyc, input int abort_cyc);
    int nk, lat, cyc;
    nk  = 4 + 2 * mode;
    lat = (mode == 0) ? 44 : (mode == 1) ? 52 : 60;
    cyc = 0;
    bus.key_mode = 2'(mode);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_done_low", 32'(bus.done), 32'h0);
    check("start_busy", 32'(bus.busy), 32'h1);
    check("start_err", 32'(bus.err), 32'h0);
    while (!bus.done && cyc < 100) begin
      bus.cipher_key = (cyc < nk) ? cur_key[cyc] : $urandom;
      if (cyc == inject_cyc) begin
        bus.start    = 1'b1;
        bus.key_mode = 2'($urandom_range(0, 3));
      end
      if (cyc == abort_cyc) reset = 1'b1;
      @(posedge clk); #1;
      cyc++;
      bus.start    = 1'b0;
      bus.key_mode = 2'(mode);
      if (reset) begin
        reset = 1'b0;
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_err", 32'(bus.err), 32'h0);
        return;
      end
    end
    check("latency", 32'(cyc), 32'(lat));
    check("end_busy", 32'(bus.busy), 32'h0);
    check("end_err", 32'(bus.err), 32'h0);
  endtask

  task automatic set_fips128();
    cur_key[0] = 32'h2b7e1516; cur_key[1] = 32'h28aed2a6;
    cur_key[2] = 32'habf71588; cur_key[3] = 32'h09cf4f3c;
    for (int i = 4; i < 8; i++) cur_key[i] = 32'h0;
  endtask

  logic [31:0] v;
  int          m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.key_mode      = 2'd0;
    bus.cipher_key    = 32'h0;
    bus.round_key_num = 4'd0;
    bus.r_index       = 2'd0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    model_clear();
    check_all("rst");

    set_fips128();
    model_expand(0);
    do_load(0, -1, -1);
    check_all("m0");
    rd(1, 0, v);  check("m0_w4", v, 32'ha0fafe17);
    rd(10, 3, v); check("m0_w43", v, 32'hb6630ca6);

    bus.key_mode = 2'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("illegal_err", 32'(bus.err), 32'h1);
    check("illegal_done", 32'(bus.done), 32'h1);
    check("illegal_busy", 32'(bus.busy), 32'h0);
    check_all("illegal");

    cur_key[0] = 32'h8e73b0f7; cur_key[1] = 32'hda0e6452; cur_key[2] = 32'hc810f32b;
    cur_key[3] = 32'h809079e5; cur_key[4] = 32'h62f8ead2; cur_key[5] = 32'h522c6b7b;
    model_expand(1);
    do_load(1, -1, -1);
    check_all("m1");
    rd(12, 3, v); check("m1_w51", v, 32'h01002202);
    rd(13, 0, v); check("m1_rk13", v, 32'h0);

    cur_key[0] = 32'h603deb10; cur_key[1] = 32'h15ca71be; cur_key[2] = 32'h2b73aef0;
    cur_key[3] = 32'h857d7781; cur_key[4] = 32'h1f352c07; cur_key[5] = 32'h3b6108d7;
    cur_key[6] = 32'h2d9810a3; cur_key[7] = 32'h0914dff4;
    model_expand(2);
    do_load(2, 20, -1);
    check_all("m2");
    rd(14, 3, v); check("m2_w59", v, 32'h706c631e);

    set_fips128();
    model_expand(0);
    do_load(0, 12, -1);
    rd(10, 3, v); check("b2b_w43", v, 32'hb6630ca6);
    check_all("b2b");

    do_load(2, -1, 25);
    model_clear();
    check_all("abort");
    set_fips128();
    model_expand(0);
    do_load(0, -1, -1);
    rd(1, 0, v);  check("post_abort_w4", v, 32'ha0fafe17);
    rd(10, 3, v); check("post_abort_w43", v, 32'hb6630ca6);

    repeat (6) begin
      m = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) cur_key[i] = $urandom;
      model_expand(m);
      do_load(m, ($urandom_range(0, 1) == 1) ? (4 + 2 * m + int'($urandom_range(1, 30))) : -1, -1);
      check_all($sformatf("rand_m%0d", m));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
